// File: rtl/pcie_io_tx_engine.sv
// pcie_io_tx_engine
//
// Completion transmit stage of the PCIe PIO path. When the receive engine
// requests a response this block waits for the memory response (for Cpl/CplD),
// emits a two-beat 3DW Cpl or CplD TLP on the 64-bit AXI-Stream TX interface,
// and pulses o_compl_done so the receive engine can take the next TLP. A
// posted write sends no TLP and only produces the done pulse.
//
// Ports:
//   i_clk, i_nrst            clock, asynchronous active-low reset
//   i_s_axis_tx_tready       core accepts the current beat
//   o_s_axis_tx_t*           TLP beat: data, keep, last, valid (all registered)
//   o_tx_src_dsc             discontinue, tied low
//   i_tx_ena                 response requested (held until o_compl_done)
//   i_tx_completion          send Cpl (no payload)
//   i_tx_with_data           send CplD (1DW payload), wins over i_tx_completion
//   o_compl_done             one-cycle pulse when the response is finished
//   i_completer_id           {bus, device, function} of this endpoint
//   i_req_*                  request header fields, latched in IDLE
//   i_resp_mem_valid/_data   single-cycle memory response, QWORD-aligned data

module pcie_io_tx_engine #(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,

    input  logic                    i_s_axis_tx_tready,
    output logic [C_DATA_WIDTH-1:0] o_s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   o_s_axis_tx_tkeep,
    output logic                    o_s_axis_tx_tlast,
    output logic                    o_s_axis_tx_tvalid,
    output logic                    o_tx_src_dsc,

    input  logic                    i_tx_ena,
    input  logic                    i_tx_completion,
    input  logic                    i_tx_with_data,
    output logic                    o_compl_done,

    input  logic [15:0]             i_completer_id,
    input  logic [2:0]              i_req_tc,
    input  logic                    i_req_td,
    input  logic                    i_req_ep,
    input  logic [1:0]              i_req_attr,
    input  logic [15:0]             i_req_rid,
    input  logic [7:0]              i_req_tag,
    input  logic [7:0]              i_req_be,
    input  logic [12:0]             i_req_addr,

    input  logic                    i_resp_mem_valid,
    input  logic [63:0]             i_resp_mem_data
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitResp,
        StHdr,
        StDw2,
        StDone
    } state_e;

    localparam logic [6:0] FmtTypeCpl  = 7'h0A;
    localparam logic [6:0] FmtTypeCplD = 7'h4A;

    state_e r_state, w_state;

    // Request fields captured in IDLE
    logic        r_with_data;
    logic [2:0]  r_tc;
    logic        r_td;
    logic        r_ep;
    logic [1:0]  r_attr;
    logic [15:0] r_rid;
    logic [7:0]  r_tag;
    logic [3:0]  r_first_be;
    logic [6:0]  r_addr;
    logic [31:0] r_data_dw;

    // Registered stream outputs and their next values
    logic [63:0] r_tdata, w_tdata;
    logic [7:0]  r_tkeep, w_tkeep;
    logic        r_tlast, w_tlast;
    logic        r_tvalid, w_tvalid;
    logic        r_done, w_done;

    logic        w_req_latch;
    logic        w_data_latch;
    logic [11:0] w_byte_count;
    logic [9:0]  w_length;
    logic [6:0]  w_fmt_type;
    logic [6:0]  w_lower_addr;
    logic [31:0] w_dw0, w_dw1, w_dw2;
    logic        w_unused_bits;

    // Last BE and upper address bits play no part in a 1DW completion
    assign w_unused_bits = ^{i_req_be[7:4], i_req_addr[12:7]};

    // Byte count from the first BE; Cpl always reports 4
    always_comb begin
        w_byte_count = 12'd1;
        if (!r_with_data) begin
            w_byte_count = 12'd4;
        end else begin
            casez (r_first_be)
                4'b1??1:                   w_byte_count = 12'd4;
                4'b01?1, 4'b1?10:          w_byte_count = 12'd3;
                4'b0011, 4'b0110, 4'b1100: w_byte_count = 12'd2;
                default:                   w_byte_count = 12'd1;
            endcase
        end
    end

    assign w_fmt_type   = r_with_data ? FmtTypeCplD : FmtTypeCpl;
    assign w_length     = r_with_data ? 10'd1 : 10'd0;
    assign w_lower_addr = r_with_data ? r_addr : 7'd0;

    assign w_dw0 = {1'b0, w_fmt_type, 1'b0, r_tc, 4'b0000, r_td, r_ep, r_attr, 2'b00, w_length};
    assign w_dw1 = {i_completer_id, 3'b000, 1'b0, w_byte_count};
    assign w_dw2 = {r_rid, r_tag, 1'b0, w_lower_addr};

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        w_state      = r_state;
        w_tdata      = r_tdata;
        w_tkeep      = r_tkeep;
        w_tlast      = r_tlast;
        w_tvalid     = r_tvalid;
        w_done       = 1'b0;
        w_req_latch  = 1'b0;
        w_data_latch = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_tx_ena) begin
                    w_req_latch = 1'b1;
                    if (i_tx_with_data || i_tx_completion) begin
                        w_state = StWaitResp;
                    end else begin
                        w_state = StDone;
                        w_done  = 1'b1;
                    end
                end
            end
            StWaitResp: begin
                if (i_resp_mem_valid) begin
                    w_data_latch = 1'b1;
                    w_state      = StHdr;
                    w_tvalid     = 1'b1;
                    w_tkeep      = 8'hFF;
                    w_tlast      = 1'b0;
                    w_tdata      = {w_dw1, w_dw0};
                end
            end
            StHdr: begin
                if (i_s_axis_tx_tready) begin
                    w_state = StDw2;
                    w_tlast = 1'b1;
                    w_tkeep = r_with_data ? 8'hFF : 8'h0F;
                    w_tdata = {(r_with_data ? r_data_dw : 32'h0), w_dw2};
                end
            end
            StDw2: begin
                if (i_s_axis_tx_tready) begin
                    w_state  = StDone;
                    w_tvalid = 1'b0;
                    w_tlast  = 1'b0;
                    w_tkeep  = 8'h00;
                    w_tdata  = 64'h0;
                    w_done   = 1'b1;
                end
            end
            // One idle cycle lets the receive engine drop i_tx_ena
            StDone: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= StIdle;
            r_tdata  <= 64'h0;
            r_tkeep  <= 8'h00;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_tdata  <= w_tdata;
            r_tkeep  <= w_tkeep;
            r_tlast  <= w_tlast;
            r_tvalid <= w_tvalid;
            r_done   <= w_done;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_with_data <= 1'b0;
            r_tc        <= 3'd0;
            r_td        <= 1'b0;
            r_ep        <= 1'b0;
            r_attr      <= 2'd0;
            r_rid       <= 16'd0;
            r_tag       <= 8'd0;
            r_first_be  <= 4'd0;
            r_addr      <= 7'd0;
        end else if (w_req_latch) begin
            r_with_data <= i_tx_with_data;
            r_tc        <= i_req_tc;
            r_td        <= i_req_td;
            r_ep        <= i_req_ep;
            r_attr      <= i_req_attr;
            r_rid       <= i_req_rid;
            r_tag       <= i_req_tag;
            r_first_be  <= i_req_be[3:0];
            r_addr      <= i_req_addr[6:0];
        end
    end

    // Pick the DW of the QWORD-aligned response that the address selects
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_data_dw <= 32'h0;
        end else if (w_data_latch) begin
            r_data_dw <= r_addr[2] ? i_resp_mem_data[63:32] : i_resp_mem_data[31:0];
        end
    end

    assign o_s_axis_tx_tdata  = r_tdata;
    assign o_s_axis_tx_tkeep  = r_tkeep;
    assign o_s_axis_tx_tlast  = r_tlast;
    assign o_s_axis_tx_tvalid = r_tvalid;
    assign o_compl_done       = r_done;
    assign o_tx_src_dsc       = 1'b0;

endmodule

// File: tb/tb_pcie_io_tx_engine.sv
`timescale 1ns/1ps

module tb_pcie_io_tx_engine;

    logic        clk = 1'b0;
    logic        nrst;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        src_dsc;
    logic        tx_ena;
    logic        tx_completion;
    logic        tx_with_data;
    logic        compl_done;
    logic [15:0] completer_id;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [7:0]  req_be;
    logic [12:0] req_addr;
    logic        resp_valid;
    logic [63:0] resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Capture of one transaction
    logic [63:0] cap_data  [4];
    logic [7:0]  cap_keep  [4];
    logic        cap_last  [4];
    int          cap_cycle [4];
    int          cap_beats;
    int          cap_done_cnt;
    int          cap_done_cycle;
    int          cap_unstable;
    int          cap_valid_cnt;

    always #5 clk = ~clk;

    pcie_io_tx_engine #(
        .C_DATA_WIDTH(64),
        .KEEP_WIDTH  (8)
    ) dut (
        .i_clk             (clk),
        .i_nrst            (nrst),
        .i_s_axis_tx_tready(tready),
        .o_s_axis_tx_tdata (tdata),
        .o_s_axis_tx_tkeep (tkeep),
        .o_s_axis_tx_tlast (tlast),
        .o_s_axis_tx_tvalid(tvalid),
        .o_tx_src_dsc      (src_dsc),
        .i_tx_ena          (tx_ena),
        .i_tx_completion   (tx_completion),
        .i_tx_with_data    (tx_with_data),
        .o_compl_done      (compl_done),
        .i_completer_id    (completer_id),
        .i_req_tc          (req_tc),
        .i_req_td          (req_td),
        .i_req_ep          (req_ep),
        .i_req_attr        (req_attr),
        .i_req_rid         (req_rid),
        .i_req_tag         (req_tag),
        .i_req_be          (req_be),
        .i_req_addr        (req_addr),
        .i_resp_mem_valid  (resp_valid),
        .i_resp_mem_data   (resp_data)
    );

    task automatic set_req(input logic wd, input logic cpl, input logic [7:0] be,
                           input logic [12:0] addr, input logic [15:0] rid,
                           input logic [7:0] tag);
        tx_with_data  = wd;
        tx_completion = cpl;
        req_be        = be;
        req_addr      = addr;
        req_rid       = rid;
        req_tag       = tag;
        req_tc        = 3'd0;
        req_td        = 1'b0;
        req_ep        = 1'b0;
        req_attr      = 2'd0;
        tx_ena        = 1'b1;
    endtask

    // Run 25 cycles after the triggering cycle (cycle 0), stalling each beat
    // for 'stall' cycles, and record accepted beats and done pulses.
    task automatic collect(input int stall);
        int          wait_cnt = 0;
        logic        held = 1'b0;
        logic [63:0] hd = '0;
        logic [7:0]  hk = '0;
        logic        hl = 1'b0;
        cap_beats      = 0;
        cap_done_cnt   = 0;
        cap_done_cycle = -1;
        cap_unstable   = 0;
        cap_valid_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            cap_data[i]  = 'x;
            cap_keep[i]  = 'x;
            cap_last[i]  = 1'bx;
            cap_cycle[i] = -1;
        end
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            resp_valid = 1'b0;
            if (tvalid && wait_cnt < stall) begin
                tready = 1'b0;
                wait_cnt++;
            end else begin
                tready = 1'b1;
            end
            @(negedge clk);
            if (tvalid) cap_valid_cnt++;
            if (held && (!tvalid || tdata !== hd || tkeep !== hk || tlast !== hl)) cap_unstable++;
            if (tvalid && !tready) begin
                if (!held) begin
                    hd = tdata;
                    hk = tkeep;
                    hl = tlast;
                end
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
            if (tvalid && tready) begin
                if (cap_beats < 4) begin
                    cap_data[cap_beats]  = tdata;
                    cap_keep[cap_beats]  = tkeep;
                    cap_last[cap_beats]  = tlast;
                    cap_cycle[cap_beats] = k;
                end
                cap_beats++;
                wait_cnt = 0;
            end
            if (compl_done) begin
                cap_done_cnt++;
                cap_done_cycle = k;
                tx_ena = 1'b0;
            end
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
        n_checks++; if (tdata !== 64'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", tdata); end
        n_checks++; if (tkeep !== 8'h00) begin n_fail++; $display("FAIL reset_tkeep: got %h want 00", tkeep); end
        n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", tlast); end
        n_checks++; if (compl_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", compl_done); end
        n_checks++; if (src_dsc !== 1'b0) begin n_fail++; $display("FAIL reset_dsc: got %b want 0", src_dsc); end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_tvalid: got %b want 0", tvalid); end
    endtask

    task automatic test_cpld();
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 8'h0F, 13'h0014, 16'h0100, 8'h05);
        // Response pulse while still IDLE must be ignored
        resp_valid = 1'b1;
        resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        // Fields are latched; changing inputs now must not matter
        req_rid    = 16'hFFFF;
        req_tag    = 8'hEE;
        req_addr   = 13'h0;
        req_be     = 8'h00;
        resp_valid = 1'b1;
        resp_data  = 64'hAAAA_BBBB_1111_2222;
        collect(0);
        n_checks++; if (cap_beats !== 2) begin n_fail++; $display("FAIL cpld_beats: got %0d want 2", cap_beats); end
        n_checks++; if (cap_data[0] !== 64'h0200_0004_4A00_0001) begin n_fail++; $display("FAIL cpld_beat0: got %h want 020000044a000001", cap_data[0]); end
        n_checks++; if (cap_keep[0] !== 8'hFF || cap_last[0] !== 1'b0) begin n_fail++; $display("FAIL cpld_beat0_ctl: got keep %h last %b want ff 0", cap_keep[0], cap_last[0]); end
        n_checks++; if (cap_data[1] !== 64'hAAAA_BBBB_0100_0514) begin n_fail++; $display("FAIL cpld_beat1: got %h want aaaabbbb01000514", cap_data[1]); end
        n_checks++; if (cap_keep[1] !== 8'hFF || cap_last[1] !== 1'b1) begin n_fail++; $display("FAIL cpld_beat1_ctl: got keep %h last %b want ff 1", cap_keep[1], cap_last[1]); end
        n_checks++; if (cap_cycle[0] !== 1 || cap_cycle[1] !== 2) begin n_fail++; $display("FAIL cpld_beat_latency: got %0d/%0d want 1/2", cap_cycle[0], cap_cycle[1]); end
        n_checks++; if (cap_done_cnt !== 1 || cap_done_cycle !== 3) begin n_fail++; $display("FAIL cpld_done: got count %0d cycle %0d want 1 at 3", cap_done_cnt, cap_done_cycle); end
    endtask

    task automatic test_cpl();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 8'h03, 13'h0014, 16'h0ABC, 8'h7F);
        @(posedge clk); #1;
        resp_valid = 1'b1;
        resp_data  = 64'h1234_5678_9ABC_DEF0;
        collect(0);
        n_checks++; if (cap_beats !== 2) begin n_fail++; $display("FAIL cpl_beats: got %0d want 2", cap_beats); end
        n_checks++; if (cap_data[0] !== 64'h0200_0004_0A00_0000) begin n_fail++; $display("FAIL cpl_beat0: got %h want 020000040a000000", cap_data[0]); end
        n_checks++; if (cap_data[1] !== 64'h0000_0000_0ABC_7F00) begin n_fail++; $display("FAIL cpl_beat1: got %h want 000000000abc7f00", cap_data[1]); end
        n_checks++; if (cap_keep[1] !== 8'h0F || cap_last[1] !== 1'b1) begin n_fail++; $display("FAIL cpl_beat1_ctl: got keep %h last %b want 0f 1", cap_keep[1], cap_last[1]); end
        n_checks++; if (cap_done_cnt !== 1 || cap_done_cycle !== 3) begin n_fail++; $display("FAIL cpl_done: got count %0d cycle %0d want 1 at 3", cap_done_cnt, cap_done_cycle); end
    endtask

    task automatic test_byte_count();
        logic [3:0]  be_tab [5] = '{4'b1001, 4'b0101, 4'b0110, 4'b1000, 4'b0000};
        logic [11:0] bc_tab [5] = '{12'd4, 12'd3, 12'd2, 12'd1, 12'd1};
        logic [63:0] exp0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            set_req(1'b1, 1'b1, {4'hF, be_tab[i]}, 13'h1FF8, 16'hBEEF, 8'h42);
            req_tc   = 3'b101;
            req_td   = 1'b1;
            req_attr = 2'b10;
            @(posedge clk); #1;
            resp_valid = 1'b1;
            resp_data  = 64'h5555_6666_7777_8888;
            collect(0);
            exp0 = {16'h0200, 4'h0, bc_tab[i], 32'h4A50_A001};
            n_checks++; if (cap_data[0] !== exp0) begin n_fail++; $display("FAIL bc_beat0[%0d]: got %h want %h", i, cap_data[0], exp0); end
            n_checks++; if (cap_data[1] !== 64'h7777_8888_BEEF_4278) begin n_fail++; $display("FAIL bc_beat1[%0d]: got %h want 77778888beef4278", i, cap_data[1]); end
            n_checks++; if (cap_done_cnt !== 1) begin n_fail++; $display("FAIL bc_done[%0d]: got %0d want 1", i, cap_done_cnt); end
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 8'h0F, 13'h0014, 16'h0100, 8'h05);
        @(posedge clk); #1;
        resp_valid = 1'b1;
        resp_data  = 64'hAAAA_BBBB_1111_2222;
        collect(5);
        n_checks++; if (cap_beats !== 2) begin n_fail++; $display("FAIL bp_beats: got %0d want 2", cap_beats); end
        n_checks++; if (cap_unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", cap_unstable); end
        n_checks++; if (cap_data[0] !== 64'h0200_0004_4A00_0001) begin n_fail++; $display("FAIL bp_beat0: got %h want 020000044a000001", cap_data[0]); end
        n_checks++; if (cap_data[1] !== 64'hAAAA_BBBB_0100_0514) begin n_fail++; $display("FAIL bp_beat1: got %h want aaaabbbb01000514", cap_data[1]); end
        n_checks++; if (cap_cycle[0] !== 6 || cap_cycle[1] !== 12) begin n_fail++; $display("FAIL bp_accept_cycles: got %0d/%0d want 6/12", cap_cycle[0], cap_cycle[1]); end
        n_checks++; if (cap_done_cnt !== 1 || cap_done_cycle !== 13) begin n_fail++; $display("FAIL bp_done: got count %0d cycle %0d want 1 at 13", cap_done_cnt, cap_done_cycle); end
    endtask

    task automatic test_posted();
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 8'h0F, 13'h0010, 16'h0100, 8'h09);
        collect(0);
        n_checks++; if (cap_valid_cnt !== 0) begin n_fail++; $display("FAIL posted_no_tvalid: got %0d valid cycles want 0", cap_valid_cnt); end
        n_checks++; if (cap_done_cnt !== 1 || cap_done_cycle !== 1) begin n_fail++; $display("FAIL posted_done: got count %0d cycle %0d want 1 at 1", cap_done_cnt, cap_done_cycle); end
    endtask

    task automatic test_reset_mid_tlp();
        @(posedge clk); #1;
        tready = 1'b0;
        set_req(1'b1, 1'b0, 8'h0F, 13'h0004, 16'h0001, 8'h10);
        @(posedge clk); #1;
        resp_valid = 1'b1;
        resp_data  = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL rst_hdr_valid: got %b want 1", tvalid); end
        #2;
        nrst   = 1'b0;
        tx_ena = 1'b0;
        #1;
        n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_async_tvalid: got %b want 0", tvalid); end
        n_checks++; if (tdata !== 64'h0 || tkeep !== 8'h00 || tlast !== 1'b0) begin n_fail++; $display("FAIL rst_async_beat: got %h %h %b want 0", tdata, tkeep, tlast); end
        repeat (2) @(negedge clk);
        nrst   = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (tvalid !== 1'b0 || compl_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume[%0d]: got valid %b done %b want 0 0", i, tvalid, compl_done); end
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 8'h0F, 13'h0004, 16'h0001, 8'h10);
        @(posedge clk); #1;
        resp_valid = 1'b1;
        resp_data  = 64'h0123_4567_89AB_CDEF;
        collect(0);
        n_checks++; if (cap_data[0] !== 64'h0200_0004_4A00_0001) begin n_fail++; $display("FAIL rst_after_beat0: got %h want 020000044a000001", cap_data[0]); end
        n_checks++; if (cap_data[1] !== 64'h0123_4567_0001_1004) begin n_fail++; $display("FAIL rst_after_beat1: got %h want 0123456700011004", cap_data[1]); end
        n_checks++; if (cap_beats !== 2 || cap_done_cnt !== 1 || cap_done_cycle !== 3) begin n_fail++; $display("FAIL rst_after_done: got beats %0d done %0d at %0d want 2 1 at 3", cap_beats, cap_done_cnt, cap_done_cycle); end
    endtask

    initial begin
        tready        = 1'b1;
        tx_ena        = 1'b0;
        tx_completion = 1'b0;
        tx_with_data  = 1'b0;
        completer_id  = 16'h0200;
        req_tc        = 3'd0;
        req_td        = 1'b0;
        req_ep        = 1'b0;
        req_attr      = 2'd0;
        req_rid       = 16'h0;
        req_tag       = 8'h0;
        req_be        = 8'h0;
        req_addr      = 13'h0;
        resp_valid    = 1'b0;
        resp_data     = 64'h0;
        nrst          = 1'b0;

        test_reset();
        test_cpld();
        test_cpl();
        test_byte_count();
        test_backpressure();
        test_posted();
        test_reset_mid_tlp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
